// File: rtl/sfx_pkg.sv
// Shared mode codes, state encoding and divider helper for sfx_tone_gen.
package sfx_pkg;

    localparam logic [1:0] MODE_STOP  = 2'd0;
    localparam logic [1:0] MODE_SIREN = 2'd1;
    localparam logic [1:0] MODE_CHOMP = 2'd2;
    localparam logic [1:0] MODE_DEATH = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SIREN = 2'd1,
        ST_CHOMP = 2'd2,
        ST_DEATH = 2'd3
    } state_e;

    // {2'b01, ramp, shift zeros}, returned wide; callers truncate
    function automatic logic [31:0] div_calc(
        input logic [31:0] ramp,
        input int          ramp_w,
        input int          shift
    );
        return ((32'd1 << ramp_w) | ramp) << shift;
    endfunction

endpackage

// File: rtl/sfx_tone_gen_if.sv
// Start/stop/busy/done handshake between game controller and sfx_tone_gen.
interface sfx_tone_gen_if;

    logic       start;
    logic [1:0] mode;
    logic       stop;
    logic       busy;
    logic       done;

    modport master (
        output start, mode, stop,
        input  busy, done
    );

    modport slave (
        input  start, mode, stop,
        output busy, done
    );

endinterface

// File: rtl/sfx_divider.sv
// Loadable down-counter with toggle flop producing the raw square wave.
module sfx_divider #(
    parameter int DIV_W = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    input  logic             idle_level,
    output logic             tick,
    output logic             out
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;

    assign tick = en && (cnt_q == '0);
    assign out  = out_q;

    // load keeps the output phase; only the period changes
    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        if (load) begin
            cnt_d = div;
        end else if (!en) begin
            cnt_d = '0;
            out_d = idle_level;
        end else if (tick) begin
            cnt_d = div;
            out_d = ~out_q;
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

endmodule

// File: rtl/sfx_tone_gen.sv
// Multi-effect square-wave speaker driver: SIREN, CHOMP, one-shot DEATH.
// Optional SFX_VOLUME_EN adds a 2-bit pwm volume gate on the vol port.
module sfx_tone_gen
    import sfx_pkg::*;
#(
    parameter int          TONE_W    = 22,
    parameter int          RAMP_W    = 7,
    parameter int          DIV_SHIFT = 5,
    parameter int          DIV_W     = 15,
    parameter logic [15:0] CHOMP_A   = 16'h2400,
    parameter logic [15:0] CHOMP_B   = 16'h1800
) (
    input  logic               clk,
    input  logic               rst_n,
    sfx_tone_gen_if.slave      ctl,
    input  logic               idle_level,
`ifdef SFX_VOLUME_EN
    input  logic [1:0]         vol,
`endif
    output logic               speaker
);

    localparam logic [TONE_W-1:0] TONE_END = {1'b0, {(TONE_W-1){1'b1}}};

    state_e            state_q, state_d;
    logic [TONE_W-1:0] tone_q, tone_d;
    logic              done_q, done_d;
    logic              restart;
    state_e            sel_st;
    logic [TONE_W-1:0] sel_tone;
    logic [RAMP_W-1:0] seg, ramp;
    logic [DIV_W-1:0]  div_sel, div;
    logic              tick, raw;

    assign restart = ctl.start && (ctl.mode != MODE_STOP);

    always_comb begin
        state_d = state_q;
        tone_d  = '0;
        done_d  = 1'b0;
        if (restart) begin
            state_d = state_e'(ctl.mode);
        end else if (ctl.start || ctl.stop) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_DEATH && tone_q == TONE_END) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
        end else if (state_q != ST_IDLE) begin
            tone_d = tone_q + TONE_W'(1);
        end
    end

    // a restart reloads with the new mode's divider at tone 0
    always_comb begin
        sel_st   = restart ? state_e'(ctl.mode) : state_q;
        sel_tone = restart ? '0 : tone_q;
        seg      = sel_tone[TONE_W-2 -: RAMP_W];
        ramp     = sel_tone[TONE_W-1] ? seg : ~seg;
        div_sel  = '0;
        unique case (1'b1)
            (sel_st == ST_SIREN):
                div_sel = DIV_W'(div_calc(32'(ramp), RAMP_W, DIV_SHIFT));
            (sel_st == ST_CHOMP):
                div_sel = sel_tone[TONE_W-2] ? DIV_W'(CHOMP_B)
                                             : DIV_W'(CHOMP_A);
            (sel_st == ST_DEATH):
                div_sel = DIV_W'(div_calc(32'(seg), RAMP_W, DIV_SHIFT));
            default:
                div_sel = '0;
        endcase
    end

    assign div = (tick || restart) ? div_sel : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tone_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tone_q  <= tone_d;
            done_q  <= done_d;
        end
    end

    sfx_divider #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (state_d != ST_IDLE),
        .load       (restart),
        .div        (div),
        .idle_level (idle_level),
        .tick       (tick),
        .out        (raw)
    );

    assign ctl.busy = (state_q != ST_IDLE);
    assign ctl.done = done_q;

`ifdef SFX_VOLUME_EN
    logic [1:0] pwm_q, pwm_d;

    assign pwm_d = pwm_q + 2'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_q <= 2'd0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    assign speaker = (state_q == ST_IDLE) ? raw : (raw & (pwm_q < vol));
`else
    assign speaker = raw;
`endif

endmodule

// File: tb/tb_sfx_tone_gen.sv
// Self-checking bench for sfx_tone_gen: vector table, corner sequences,
// random stimulus against a cycle-level behavioural model.
module tb_sfx_tone_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic idle_level = 1'b0;
  logic speaker;
`ifdef SFX_VOLUME_EN
  logic [1:0] vol = 2'd3;
`endif

  sfx_tone_gen_if bus();

  sfx_tone_gen #(
    .TONE_W(8), .RAMP_W(3), .DIV_SHIFT(0), .DIV_W(6),
    .CHOMP_A(16'd12), .CHOMP_B(16'd6)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ctl(bus),
    .idle_level(idle_level),
`ifdef SFX_VOLUME_EN
    .vol(vol),
`endif
    .speaker(speaker)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // behavioural model: state 0 idle, 1 siren, 2 chomp, 3 death
  int m_state, m_tone, m_cnt, m_pwm;
  bit m_raw, m_done;

  function automatic int model_div(int st, int tone);
    int seg;
    seg = (tone / 16) % 8;
    case (st)
      1: return 8 + ((tone >= 128) ? seg : 7 - seg);
      2: return (((tone / 64) % 2) == 1) ? 6 : 12;
      3: return 8 + seg;
      default: return 0;
    endcase
  endfunction

  function automatic void model_step(bit r, bit s, int md, bit sp, bit idl);
    m_done = 0;
    if (!r) begin
      m_state = 0; m_tone = 0; m_cnt = 0; m_raw = 0; m_pwm = 0;
    end else begin
      m_pwm = (m_pwm + 1) % 4;
      if (s && md != 0) begin
        m_state = md; m_tone = 0; m_cnt = model_div(md, 0);
      end else if (s || sp) begin
        m_state = 0; m_tone = 0; m_cnt = 0; m_raw = idl;
      end else if (m_state == 0) begin
        m_raw = idl;
      end else if (m_state == 3 && m_tone == 127) begin
        m_state = 0; m_done = 1; m_tone = 0; m_cnt = 0; m_raw = idl;
      end else begin
        if (m_cnt == 0) begin
          m_cnt = model_div(m_state, m_tone);
          m_raw = !m_raw;
        end else begin
          m_cnt = m_cnt - 1;
        end
        m_tone = (m_tone + 1) % 256;
      end
    end
  endfunction

  function automatic bit exp_spk();
`ifdef SFX_VOLUME_EN
    if (m_state != 0) return m_raw && (m_pwm < int'(vol));
`endif
    return m_raw;
  endfunction

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(bit r, bit s, logic [1:0] md, bit sp, bit idl);
    rst_n = r;
    bus.start = s;
    bus.mode = md;
    bus.stop = sp;
    idle_level = idl;
    @(posedge clk);
    model_step(r, s, int'(md), sp, idl);
    #1;
    check("busy", int'(bus.busy), int'(m_state != 0));
    check("done", int'(bus.done), int'(m_done));
    check("speaker", int'(speaker), int'(exp_spk()));
  endtask

  typedef struct {
    bit r; bit s; logic [1:0] md; bit sp; bit idl;
    int n; bit eb; bit ed; bit es;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int done_at, last_t, gap, exp_gap, saw7;
    bit prev;
    bit rr, rs, rsp, ridl;
    logic [1:0] rmd;

    bus.start = 0; bus.mode = 0; bus.stop = 0;

    // {rst_n, start, mode, stop, idle, cycles, busy, done, speaker}
    tbl.push_back('{0, 0, 2'd0, 0, 0,  2, 0, 0, 0});
    tbl.push_back('{1, 0, 2'd0, 0, 1,  1, 0, 0, 1});
    tbl.push_back('{1, 1, 2'd1, 0, 1,  1, 1, 0, 1});
    tbl.push_back('{1, 0, 2'd0, 0, 1, 15, 1, 0, 1});
    tbl.push_back('{1, 0, 2'd0, 0, 1,  1, 1, 0, 0});
    tbl.push_back('{1, 0, 2'd0, 0, 1, 15, 1, 0, 0});
    tbl.push_back('{1, 0, 2'd0, 0, 1,  1, 1, 0, 1});
    tbl.push_back('{1, 0, 2'd0, 1, 0,  1, 0, 0, 0});
    tbl.push_back('{1, 1, 2'd3, 0, 0,  1, 1, 0, 0});
    tbl.push_back('{1, 0, 2'd0, 0, 0,  8, 1, 0, 0});
    tbl.push_back('{1, 0, 2'd0, 0, 0,  1, 1, 0, 1});
    tbl.push_back('{1, 1, 2'd0, 0, 1,  1, 0, 0, 1});
    tbl.push_back('{1, 1, 2'd2, 0, 1,  1, 1, 0, 1});
    tbl.push_back('{1, 0, 2'd0, 0, 1, 12, 1, 0, 1});
    tbl.push_back('{1, 0, 2'd0, 0, 1,  1, 1, 0, 0});
    tbl.push_back('{1, 0, 2'd0, 1, 0,  1, 0, 0, 0});

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++)
        step(tbl[i].r, (k == 0) ? tbl[i].s : 1'b0, tbl[i].md,
             (k == 0) ? tbl[i].sp : 1'b0, tbl[i].idl);
      check($sformatf("vec%0d_busy", i), int'(bus.busy), int'(tbl[i].eb));
      check($sformatf("vec%0d_done", i), int'(bus.done), int'(tbl[i].ed));
`ifndef SFX_VOLUME_EN
      check($sformatf("vec%0d_spk", i), int'(speaker), int'(tbl[i].es));
`endif
    end

    // reset held three cycles in the middle of a siren
    step(1, 1, 2'd1, 0, 1);
    for (int i = 0; i < 40; i++) step(1, 0, 2'd0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 2'd0, 0, 1);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_spk", int'(speaker), 0);
    end

    // full death sweep: done exactly 128 edges after the start edge
    step(1, 1, 2'd3, 0, 1);
    done_at = -1;
    for (int i = 1; i <= 200 && done_at < 0; i++) begin
      step(1, 0, 2'd0, 0, 1);
      if (bus.done) done_at = i;
    end
    check("death_done_cycle", done_at, 128);
    check("death_busy_at_done", int'(bus.busy), 0);
    step(1, 0, 2'd0, 0, 1);
    check("death_done_width", int'(bus.done), 0);
    check("death_idle_spk", int'(speaker), 1);

    // chomp half-periods: 13 while tone[6]=0, 7 while tone[6]=1
    step(1, 1, 2'd2, 0, 0);
    last_t = 0; saw7 = 0; prev = speaker;
    for (int t = 1; t <= 200; t++) begin
      step(1, 0, 2'd0, 0, 0);
      if (speaker != prev) begin
        gap = t - last_t;
        exp_gap = ((((last_t == 0) ? 0 : last_t - 1) / 64) % 2 == 1) ? 7 : 13;
        check("chomp_gap", gap, exp_gap);
        if (gap == 7) saw7 = 1;
        last_t = t;
        prev = speaker;
      end
    end
    check("chomp_saw_short", saw7, 1);
    step(1, 0, 2'd0, 1, 0);
    check("chomp_stop_busy", int'(bus.busy), 0);

    // start and stop together during death: restart wins, tone cleared
    step(1, 1, 2'd3, 0, 0);
    for (int i = 0; i < 50; i++) step(1, 0, 2'd0, 0, 0);
    step(1, 1, 2'd3, 1, 0);
    check("restart_busy", int'(bus.busy), 1);
    done_at = -1;
    for (int i = 1; i <= 200 && done_at < 0; i++) begin
      step(1, 0, 2'd0, 0, 0);
      if (bus.done) done_at = i;
    end
    check("restart_done_cycle", done_at, 128);

`ifdef SFX_VOLUME_EN
    vol = 2'd0;
    step(1, 1, 2'd1, 0, 1);
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 2'd0, 0, 1);
      check("vol0_mute", int'(speaker), 0);
    end
    vol = 2'd2;
    for (int i = 0; i < 80; i++) step(1, 0, 2'd0, 0, 1);
    step(1, 0, 2'd0, 1, 1);
`endif

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rr   = ($urandom_range(0, 999) > 3);
      rs   = ($urandom_range(0, 99) < 2);
      rmd  = 2'($urandom_range(0, 3));
      rsp  = ($urandom_range(0, 99) < 1);
      ridl = 1'($urandom_range(0, 1));
`ifdef SFX_VOLUME_EN
      if ($urandom_range(0, 99) < 3) vol = 2'($urandom_range(0, 3));
`endif
      step(rr, rs, rmd, rsp, ridl);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
